// File: rtl/fixed_point_divider.sv
// Sequential signed fixed-point divider, M.Q two's complement (W = M+Q+1 bits).
// Restoring division on magnitudes, one quotient bit per clock, saturating result.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   in_valid/in_ready      operand handshake (ready only while idle)
//   dividend, divisor      signed M.Q operands
//   out_valid/out_ready    result handshake (result held until accepted)
//   quotient               signed M.Q result
//   overflow               result saturated
//   div_by_zero            divisor was zero
module fixed_point_divider #(
  parameter int unsigned M = 7,
  parameter int unsigned Q = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M+Q:0] dividend,
  input  logic [M+Q:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M+Q:0] quotient,
  output logic         overflow,
  output logic         div_by_zero
);

  localparam int unsigned W    = M + Q + 1;
  localparam int unsigned ITER = W + Q;
  localparam int unsigned CW   = $clog2(ITER);

  localparam logic [ITER-1:0] POS_LIMIT = ITER'((1 << (W - 1)) - 1);
  localparam logic [ITER-1:0] NEG_LIMIT = ITER'(1 << (W - 1));
  localparam logic [W-1:0]    POS_SAT   = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]    NEG_SAT   = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

  state_t state, state_next;

  logic [CW-1:0]   counter;
  logic [W-1:0]    rem;
  logic [ITER-1:0] dvd;
  logic [ITER-1:0] qm;
  logic [W-1:0]    dvsr_mag;
  logic            neg;

  logic            accept;
  logic [W-1:0]    dividend_mag;
  logic [W-1:0]    divisor_mag;
  logic [W:0]      rem_shift;
  logic [W:0]      rem_diff;
  logic            rem_ge;
  logic [ITER-1:0] qm_next;
  logic [W-1:0]    res_q;
  logic            res_ovf;
  logic [W-1:0]    zero_q;

  // Next-state logic
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        accept = in_valid;
        if (in_valid) state_next = (divisor == W'(0)) ? DONE : DIVIDE;
      end
      DIVIDE:  if (counter == CW'(0)) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register with registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
    end
  end

  // Operand magnitudes, one restoring step, and saturated result of the final step
  always_comb begin
    dividend_mag = dividend[W-1] ? W'(0) - dividend : dividend;
    divisor_mag  = divisor[W-1]  ? W'(0) - divisor  : divisor;
    rem_shift    = {rem, dvd[ITER-1]};
    rem_diff     = rem_shift - {1'b0, dvsr_mag};
    rem_ge       = (rem_shift >= {1'b0, dvsr_mag});
    qm_next      = {qm[ITER-2:0], rem_ge};
    res_q        = neg ? W'(0) - qm_next[W-1:0] : qm_next[W-1:0];
    res_ovf      = 1'b0;
    if (!neg && qm_next > POS_LIMIT) begin
      res_q   = POS_SAT;
      res_ovf = 1'b1;
    end else if (neg && qm_next > NEG_LIMIT) begin
      res_q   = NEG_SAT;
      res_ovf = 1'b1;
    end
    zero_q = (dividend == W'(0)) ? W'(0) : (dividend[W-1] ? NEG_SAT : POS_SAT);
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      counter     <= '0;
      rem         <= '0;
      dvd         <= '0;
      qm          <= '0;
      dvsr_mag    <= '0;
      neg         <= 1'b0;
      quotient    <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      dvsr_mag <= divisor_mag;
      neg      <= dividend[W-1] ^ divisor[W-1];
      rem      <= '0;
      qm       <= '0;
      dvd      <= {dividend_mag, {Q{1'b0}}};
      counter  <= CW'(ITER - 1);
      if (divisor == W'(0)) begin
        quotient    <= zero_q;
        overflow    <= 1'b0;
        div_by_zero <= 1'b1;
      end
    end else if (state == DIVIDE) begin
      rem     <= rem_ge ? rem_diff[W-1:0] : rem_shift[W-1:0];
      dvd     <= {dvd[ITER-2:0], 1'b0};
      qm      <= qm_next;
      counter <= counter - CW'(1);
      if (counter == CW'(0)) begin
        quotient    <= res_q;
        overflow    <= res_ovf;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fixed_point_divider.sv
// Directed self-checking bench for fixed_point_divider (M=7, Q=8).
module tb_fixed_point_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic        overflow;
  logic        div_by_zero;

  int n_vec = 0;
  int n_err = 0;

  fixed_point_divider #(.M(7), .Q(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .overflow(overflow), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Drive one division; return result and edges from accept to out_valid (-1 on timeout)
  task automatic run_div(input logic [15:0] a, input logic [15:0] b, input bit drain,
                         output logic [15:0] q, output logic ovf, output logic dz,
                         output int lat);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 16'hDEAD;
    divisor  = 16'h0000;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    q   = quotient;
    ovf = overflow;
    dz  = div_by_zero;
    if (drain) begin
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++; if (quotient !== 16'h0000) begin n_err++; $display("FAIL reset_quotient got %h want 0000", quotient); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b want 0", overflow); end
    n_vec++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
  endtask

  task automatic test_basic();
    logic [15:0] q; logic ovf, dz; int lat;
    run_div(16'h0180, 16'h0080, 1'b1, q, ovf, dz, lat);
    n_vec++; if (q !== 16'h0300) begin n_err++; $display("FAIL basic_q got %h want 0300", q); end
    n_vec++; if ({ovf, dz} !== 2'b00) begin n_err++; $display("FAIL basic_flags got %b want 00", {ovf, dz}); end
    n_vec++; if (lat !== 24) begin n_err++; $display("FAIL basic_latency got %0d want 24", lat); end
    n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL basic_drain got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_signs();
    logic [15:0] a[3] = '{16'h0100, 16'hFF00, 16'hFF00};
    logic [15:0] b[3] = '{16'h0300, 16'h0300, 16'h0400};
    logic [15:0] e[3] = '{16'h0055, 16'hFFAB, 16'hFFC0};
    logic [15:0] q; logic ovf, dz; int lat;
    for (int i = 0; i < 3; i++) begin
      run_div(a[i], b[i], 1'b1, q, ovf, dz, lat);
      n_vec++; if (q !== e[i] || ovf !== 1'b0 || dz !== 1'b0) begin
        n_err++; $display("FAIL signs_%0d got %h ovf=%b dbz=%b want %h 0 0", i, q, ovf, dz, e[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] a[3] = '{16'h6400, 16'h8000, 16'h8000};
    logic [15:0] b[3] = '{16'h0001, 16'h0100, 16'hFF00};
    logic [15:0] e[3] = '{16'h7FFF, 16'h8000, 16'h7FFF};
    logic        eo[3] = '{1'b1, 1'b0, 1'b1};
    logic [15:0] q; logic ovf, dz; int lat;
    for (int i = 0; i < 3; i++) begin
      run_div(a[i], b[i], 1'b1, q, ovf, dz, lat);
      n_vec++; if (q !== e[i] || ovf !== eo[i] || dz !== 1'b0) begin
        n_err++; $display("FAIL ovf_%0d got %h ovf=%b dbz=%b want %h %b 0", i, q, ovf, dz, e[i], eo[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [15:0] q; logic ovf, dz; int lat;
    run_div(16'hFF00, 16'h0000, 1'b1, q, ovf, dz, lat);
    n_vec++; if (q !== 16'h8000 || dz !== 1'b1 || ovf !== 1'b0) begin
      n_err++; $display("FAIL dbz_neg got %h dbz=%b ovf=%b want 8000 1 0", q, dz, ovf);
    end
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL dbz_latency got %0d want 1", lat); end
    run_div(16'h0000, 16'h0000, 1'b1, q, ovf, dz, lat);
    n_vec++; if (q !== 16'h0000 || dz !== 1'b1 || ovf !== 1'b0) begin
      n_err++; $display("FAIL dbz_zero got %h dbz=%b ovf=%b want 0000 1 0", q, dz, ovf);
    end
    run_div(16'h0300, 16'h0000, 1'b1, q, ovf, dz, lat);
    n_vec++; if (q !== 16'h7FFF || dz !== 1'b1 || ovf !== 1'b0) begin
      n_err++; $display("FAIL dbz_pos got %h dbz=%b ovf=%b want 7FFF 1 0", q, dz, ovf);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] q; logic ovf, dz; int lat;
    run_div(16'h6400, 16'h0001, 1'b0, q, ovf, dz, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 16'h7FFF || overflow !== 1'b1) begin
        n_err++; $display("FAIL hold_%0d got vld=%b rdy=%b q=%h ovf=%b want 1 0 7FFF 1",
                          i, out_valid, in_ready, quotient, overflow);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL hold_release got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
  endtask

  // in_valid pulse with other operands while busy must be ignored
  task automatic test_busy_ignore();
    int lat = -1;
    @(negedge clk);
    dividend = 16'h0100;
    divisor  = 16'h0300;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
      if (i == 5) begin
        dividend = 16'h0180;
        divisor  = 16'h0080;
        in_valid = 1'b1;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL busy_in_ready got %b want 0", in_ready); end
      end
      if (i == 6) in_valid = 1'b0;
    end
    n_vec++; if (lat !== 24 || quotient !== 16'h0055) begin
      n_err++; $display("FAIL busy_result got lat=%0d q=%h want 24 0055", lat, quotient);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL busy_no_second got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_abort();
    logic [15:0] q; logic ovf, dz; int lat;
    int seen = 0;
    @(negedge clk);
    dividend = 16'h0180;
    divisor  = 16'h0080;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL abort_state got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_vec++; if (seen !== 0) begin n_err++; $display("FAIL abort_no_result got %0d valid cycles want 0", seen); end
    run_div(16'h0200, 16'h0100, 1'b1, q, ovf, dz, lat);
    n_vec++; if (q !== 16'h0200 || ovf !== 1'b0 || dz !== 1'b0 || lat !== 24) begin
      n_err++; $display("FAIL abort_next got q=%h ovf=%b dbz=%b lat=%0d want 0200 0 0 24", q, ovf, dz, lat);
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    test_reset();
    test_basic();
    test_signs();
    test_overflow();
    test_div_zero();
    test_backpressure();
    test_busy_ignore();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
